link_serial_tx: RTL and testbench
=================================

// Module: link_serial_tx
// PURPOSE
//  Transmit end of the board-to-board audio link. Takes the byte stream from
//  transportSend (sending/packetOut) and buffers it in a small FIFO.
//  Drives it onto one serial wire as framed async characters: start, 8 data LSB-first, optional even parity, stop.
//  The far board's serial deserializer rebuilds the sending/packetOut pair for transportRcv.
// PARAMETERS
//  CLKS_PER_BIT   234  clk cycles per serial bit (27 MHz / 234 ~ 115200 baud)
//  FIFO_AW        4    FIFO address width; depth = 2**FIFO_AW = 16 bytes
//  PARITY_EN      1    1 = insert even-parity bit after data, 0 = no parity bit
// PORTS
//  clk         in   1        system clock
//  reset       in   1        asynchronous, active-high reset
//  byteIn      in   8        byte from transportSend packetOut
//  byteValid   in   1        byteIn valid this cycle (transportSend sending)
//  txd         out  1        serial line, idle high
//  linkBusy    out  1        1 while a frame is on the wire or FIFO non-empty
//  fifoCount   out  FIFO_AW+1  bytes currently buffered (0..2**FIFO_AW)
//  overflow    out  1        sticky: a byte was dropped because FIFO was full
// BEHAVIOUR
//  Reset (async, any time, incl. mid-frame): txd=1 immediately, linkBusy=0,
//   fifoCount=0, overflow=0, FIFO pointers cleared, state=IDLE, bit/baud counters 0.
//   A partially sent frame is abandoned; no completion.
//  No ready back to sender: byteValid is a push, never stalled.
//  FIFO push: byteValid=1 and (fifoCount<DEPTH or a pop occurs same cycle) ->
//   byte stored; else byte dropped and overflow<=1 (held until reset).
//  fifoCount updates on the clock edge after push/pop; push+pop same cycle -> unchanged.
//  Pointers wrap modulo DEPTH; count is FIFO_AW+1 bits so full and empty are distinct.
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//   IDLE: txd=1. If fifoCount!=0: pop head into shift reg, go START.
//   START: txd=0 for CLKS_PER_BIT cycles -> DATA.
//   DATA: txd=shift[0]; shift right every CLKS_PER_BIT cycles; after 8 bits ->
//     PARITY if PARITY_EN else STOP.
//   PARITY: txd = ^byte (even parity: total ones in data+parity is even),
//     CLKS_PER_BIT cycles -> STOP.
//   STOP: txd=1 for CLKS_PER_BIT cycles -> IDLE.
//  IDLE lasts exactly 1 cycle when FIFO non-empty, so frame period =
//   (10+PARITY_EN)*CLKS_PER_BIT + 1 cycles back-to-back.
//  Latency: byteValid at edge t into empty FIFO with FSM idle -> stored t+1,
//   popped t+1 (IDLE), txd falls at edge t+2.
//  Byte in flight is held in the shift reg, not the FIFO; its slot is freed at pop.
//  txd is registered (no glitches). linkBusy = (state!=IDLE) | (fifoCount!=0).
//  Baud counter counts 0..CLKS_PER_BIT-1 and resets on every state change.
// TESTING (bench with CLKS_PER_BIT=4, FIFO_AW=4)
//  1. Single byte 0xA5, PARITY_EN=1 -> txd bits, 4 clk each:
//     0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, parity 0, stop). linkBusy falls after stop.
//  2. PARITY_EN=0, byte 0x01 -> 0,1,0,0,0,0,0,0,0,1. Frame is exactly 40 cycles.
//     Next queued byte starts 1 cycle later.
//  3. 17 consecutive byteValid cycles (0x00..0x10) into idle link.
//     First byte popped at once, 16 buffered, fifoCount=16, overflow=0.
//     All 17 appear on txd in order.
//  4. 18 consecutive bytes -> 18th (0x11) dropped, overflow=1 and stays 1.
//     Exactly 17 frames sent.
//  5. FIFO full (16), push coincident with IDLE pop -> byte accepted,
//     fifoCount stays 16, overflow=0.
//  6. Assert reset during DATA bit 3 -> txd=1 same cycle (async), fifoCount=0.
//     After release, no frame is sent until a new byteValid.

Source files
------------

// File: rtl/link_serial_tx.sv
// link_serial_tx: transmit end of the board-to-board audio link.
// Bytes pushed on byteIn/byteValid are buffered in a small FIFO and sent on
// txd as async characters: start bit, 8 data bits LSB first, optional even
// parity bit, stop bit. There is no back-pressure: a push into a full FIFO
// (with no pop in the same cycle) is dropped and latched in the overflow flag.

module link_serial_tx #(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_AW      = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         byteIn,
    input  logic               byteValid,
    output logic               txd,
    output logic               linkBusy,
    output logic [FIFO_AW:0]   fifoCount,
    output logic               overflow
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int                DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]  DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]          mem_q [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]    count_q,  count_d;
    logic                ovf_q,    ovf_d;

    logic [2:0]          state_q,  state_d;
    logic [BAUD_W-1:0]   baud_q,   baud_d;
    logic [2:0]          bit_q,    bit_d;
    logic [7:0]          shift_q,  shift_d;
    logic                par_q,    par_d;
    logic                txd_q,    txd_d;

    logic                pop;
    logic                push;
    logic                baud_end;
    logic [7:0]          head_byte;

    // The head byte is read combinationally so that the single IDLE cycle
    // can both see a non-empty FIFO and load the shift register.
    assign head_byte = mem_q[rd_ptr_q];
    assign baud_end  = (baud_q == BAUD_LAST);

    // FIFO handshake: pop whenever the FSM is idle with data waiting; a push
    // is accepted when there is room or a slot is freed by the same-cycle pop.
    always_comb begin
        pop  = (state_q == ST_IDLE) && (count_q != '0);
        push = byteValid && ((count_q != DEPTH_CNT) || pop);
    end

    // FIFO pointer, occupancy and sticky overflow next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase
        if (byteValid && !push) begin
            ovf_d = 1'b1;
        end
    end

    // Framing FSM: sequences start/data/parity/stop, each CLKS_PER_BIT long.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                bit_d  = 3'd0;
                if (pop) begin
                    shift_d = head_byte;
                    par_d   = ^head_byte;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                baud_d  = '0;
                bit_d   = 3'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level for the upcoming cycle, derived from the next state so that
    // txd comes straight from a flop and changes on the state transition edge.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[0];
            ST_PARITY: txd_d = par_d;
            default:   txd_d = 1'b1;
        endcase
    end

    // FIFO storage: written only, no reset needed since pointers are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= byteIn;
        end
    end

    // All control state; reset abandons any frame in progress and idles the line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            par_q    <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            txd_q    <= txd_d;
        end
    end

    // Outputs.
    always_comb begin
        txd       = txd_q;
        fifoCount = count_q;
        overflow  = ovf_q;
        linkBusy  = (state_q != ST_IDLE) || (count_q != '0);
    end

endmodule

// File: tb/tb_link_serial_tx.sv
// Testbench for link_serial_tx: one instance with parity, one without,
// CLKS_PER_BIT=4, FIFO_AW=4. Directed vectors plus multi-cycle sequences.

module tb_link_serial_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] byte_p = 8'h00, byte_n = 8'h00;
    logic       valid_p = 1'b0, valid_n = 1'b0;
    logic       txd_p, txd_n, busy_p, busy_n, ovf_p, ovf_n;
    logic [4:0] cnt_p, cnt_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    link_serial_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(4), .PARITY_EN(1)) dut_p (
        .clk(clk), .reset(rst), .byteIn(byte_p), .byteValid(valid_p),
        .txd(txd_p), .linkBusy(busy_p), .fifoCount(cnt_p), .overflow(ovf_p));

    link_serial_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(4), .PARITY_EN(0)) dut_n (
        .clk(clk), .reset(rst), .byteIn(byte_n), .byteValid(valid_n),
        .txd(txd_n), .linkBusy(busy_n), .fifoCount(cnt_n), .overflow(ovf_n));

    typedef struct {
        logic [7:0]  data;
        bit          sel;       // 0 = parity instance, 1 = no-parity instance
        int          nbits;
        logic [10:0] exp_bits;  // bit i = i-th serial bit on the wire
    } vec_t;

    vec_t vecs[9];

    function automatic logic cur_txd(input bit sel);
        return sel ? txd_n : txd_p;
    endfunction
    function automatic logic cur_busy(input bit sel);
        return sel ? busy_n : busy_p;
    endfunction
    function automatic logic [4:0] cur_cnt(input bit sel);
        return sel ? cnt_n : cnt_p;
    endfunction
    function automatic logic cur_ovf(input bit sel);
        return sel ? ovf_n : ovf_p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin
            valid_n = v;
            byte_n  = d;
        end else begin
            valid_p = v;
            byte_p  = d;
        end
    endtask

    // Called on a negedge; presents n consecutive bytes first, first+1, ...
    task automatic push_seq(input bit sel, input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            set_in(sel, 1'b1, first + 8'(i));
            @(negedge clk);
        end
        set_in(sel, 1'b0, 8'h00);
    endtask

    // Waits (bounded) for the start bit, then checks every clock of the frame.
    // Returns on the negedge following the last stop-bit cycle.
    task automatic check_frame(input bit sel, input logic [10:0] exp, input int nbits,
                               input logic [7:0] data, output int w);
        w = 0;
        while (cur_txd(sel) !== 1'b0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) begin
            chk("start_timeout", 32'(w), 32'd0);
        end else begin
            for (int b = 0; b < nbits; b++) begin
                for (int c = 0; c < CPB; c++) begin
                    chk($sformatf("txd_%02h_b%0d", data, b), 32'(cur_txd(sel)), 32'(exp[b]));
                    chk($sformatf("busy_%02h_b%0d", data, b), 32'(cur_busy(sel)), 32'd1);
                    @(negedge clk);
                end
            end
        end
        $display("frame dut=%0d data=%02h wait=%0d", sel, data, w);
    endtask

    function automatic logic [10:0] par_frame(input logic [7:0] d);
        return {1'b1, ^d, d, 1'b0};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Watchdog so the bench can never hang.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int zeros;

        vecs[0] = '{8'hA5, 1'b0, 11, {1'b1, 1'b0, 8'hA5, 1'b0}};
        vecs[1] = '{8'h01, 1'b0, 11, {1'b1, 1'b1, 8'h01, 1'b0}};
        vecs[2] = '{8'hFF, 1'b0, 11, {1'b1, 1'b0, 8'hFF, 1'b0}};
        vecs[3] = '{8'h80, 1'b0, 11, {1'b1, 1'b1, 8'h80, 1'b0}};
        vecs[4] = '{8'h3C, 1'b0, 11, {1'b1, 1'b0, 8'h3C, 1'b0}};
        vecs[5] = '{8'h7F, 1'b0, 11, {1'b1, 1'b1, 8'h7F, 1'b0}};
        vecs[6] = '{8'h00, 1'b0, 11, {1'b1, 1'b0, 8'h00, 1'b0}};
        vecs[7] = '{8'h01, 1'b1, 10, {1'b0, 1'b1, 8'h01, 1'b0}};
        vecs[8] = '{8'hC3, 1'b1, 10, {1'b0, 1'b1, 8'hC3, 1'b0}};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_txd_p", 32'(txd_p), 32'd1);
        chk("rst_txd_n", 32'(txd_n), 32'd1);
        chk("rst_busy_p", 32'(busy_p), 32'd0);
        chk("rst_cnt_p", 32'(cnt_p), 32'd0);
        chk("rst_ovf_p", 32'(ovf_p), 32'd0);
        chk("rst_busy_n", 32'(busy_n), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_txd_p", 32'(txd_p), 32'd1);

        // Table-driven single frames
        for (int i = 0; i < 9; i++) begin
            push_seq(vecs[i].sel, vecs[i].data, 1);
            chk("busy_after_push", 32'(cur_busy(vecs[i].sel)), 32'd1);
            chk("cnt_after_push", 32'(cur_cnt(vecs[i].sel)), 32'd1);
            check_frame(vecs[i].sel, vecs[i].exp_bits, vecs[i].nbits, vecs[i].data, w);
            chk("latency", 32'(w), 32'd1);
            chk("busy_after_frame", 32'(cur_busy(vecs[i].sel)), 32'd0);
            chk("txd_after_frame", 32'(cur_txd(vecs[i].sel)), 32'd1);
            repeat (3) @(negedge clk);
        end

        // No parity: two queued bytes, second starts one cycle after 40-cycle frame
        push_seq(1'b1, 8'h01, 2);
        check_frame(1'b1, {1'b0, 1'b1, 8'h01, 1'b0}, 10, 8'h01, w);
        check_frame(1'b1, {1'b0, 1'b1, 8'h02, 1'b0}, 10, 8'h02, w);
        chk("b2b_gap_nopar", 32'(w), 32'd1);
        chk("b2b_busy_end", 32'(busy_n), 32'd0);

        // 17 consecutive pushes into an idle link
        fork
            begin
                push_seq(1'b0, 8'h00, 17);
                chk("fill17_cnt", 32'(cnt_p), 32'd16);
                chk("fill17_ovf", 32'(ovf_p), 32'd0);
            end
            begin
                for (int i = 0; i < 17; i++) begin
                    check_frame(1'b0, par_frame(8'(i)), 11, 8'(i), w);
                    if (i > 0) chk("fill17_gap", 32'(w), 32'd1);
                end
                chk("fill17_busy_end", 32'(busy_p), 32'd0);
            end
        join

        // 18 consecutive pushes: last one dropped, overflow sticky
        fork
            begin
                push_seq(1'b0, 8'h00, 18);
                chk("fill18_cnt", 32'(cnt_p), 32'd16);
                chk("fill18_ovf", 32'(ovf_p), 32'd1);
            end
            begin
                for (int i = 0; i < 17; i++) begin
                    check_frame(1'b0, par_frame(8'(i)), 11, 8'(i), w);
                end
            end
        join
        zeros = 0;
        for (int i = 0; i < 60; i++) begin
            if (txd_p !== 1'b1) zeros++;
            @(negedge clk);
        end
        chk("fill18_no_extra_frame", 32'(zeros), 32'd0);
        chk("fill18_ovf_sticky", 32'(ovf_p), 32'd1);
        chk("fill18_cnt_end", 32'(cnt_p), 32'd0);
        do_reset();
        chk("ovf_cleared_by_reset", 32'(ovf_p), 32'd0);

        // Full FIFO, push coincident with the IDLE pop
        fork
            begin
                push_seq(1'b0, 8'h20, 17);
                chk("full_cnt", 32'(cnt_p), 32'd16);
            end
            begin
                check_frame(1'b0, par_frame(8'h20), 11, 8'h20, w);
                set_in(1'b0, 1'b1, 8'h77);
                @(negedge clk);
                set_in(1'b0, 1'b0, 8'h00);
                chk("coinc_cnt", 32'(cnt_p), 32'd16);
                chk("coinc_ovf", 32'(ovf_p), 32'd0);
                for (int i = 1; i < 17; i++) begin
                    check_frame(1'b0, par_frame(8'h20 + 8'(i)), 11, 8'h20 + 8'(i), w);
                end
                check_frame(1'b0, par_frame(8'h77), 11, 8'h77, w);
                chk("coinc_last_gap", 32'(w), 32'd1);
                chk("coinc_busy_end", 32'(busy_p), 32'd0);
                chk("coinc_ovf_end", 32'(ovf_p), 32'd0);
            end
        join

        // Asynchronous reset during data bit 3 of 0xA5 (bit value 0)
        push_seq(1'b0, 8'hA5, 3);   // A5 in flight, two bytes buffered
        chk("pre_rst_cnt", 32'(cnt_p), 32'd2);
        repeat (16) @(negedge clk);
        chk("pre_rst_txd_bit3", 32'(txd_p), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_txd", 32'(txd_p), 32'd1);
        chk("async_rst_cnt", 32'(cnt_p), 32'd0);
        chk("async_rst_busy", 32'(busy_p), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        zeros = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd_p !== 1'b1 || busy_p !== 1'b0) zeros++;
        end
        chk("post_rst_silent", 32'(zeros), 32'd0);
        push_seq(1'b0, 8'h5A, 1);
        check_frame(1'b0, {1'b1, 1'b0, 8'h5A, 1'b0}, 11, 8'h5A, w);
        chk("post_rst_latency", 32'(w), 32'd1);
        chk("post_rst_busy_end", 32'(busy_p), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
